// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI4-Stream width converters.
// Default widths match the 512-bit stack core to 64-bit MAC boundary.
package axis_pkg;

  localparam int AXIS_IN_WIDTH  = 512;
  localparam int AXIS_OUT_WIDTH = 64;
  localparam int AXIS_RATIO     = AXIS_IN_WIDTH / AXIS_OUT_WIDTH;
  localparam int AXIS_IDX_W     = $clog2(AXIS_RATIO);

  // Widest keep vector the encoder accepts (4096-bit data).
  localparam int KEEP_MAX_W = 512;

  typedef logic [AXIS_IDX_W-1:0] seg_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dc_state_t;

  // Index of the highest segment holding at least one enabled byte.
  // An all-zero keep yields segment 0.
  function automatic int keep_last_seg(input logic [KEEP_MAX_W-1:0] keep,
                                       input int ratio,
                                       input int seg_bytes);
    int seg;
    seg = 0;
    for (int b = 0; b < KEEP_MAX_W; b++) begin
      if (b < ratio * seg_bytes && keep[b]) seg = b / seg_bytes;
    end
    return seg;
  endfunction

endpackage

// File: rtl/axis_width_downconverter.sv
// AXI4-Stream width reducer: one wide beat is replayed as RATIO narrow beats,
// LSB segment first, with trailing empty segments trimmed on tlast beats.
module axis_width_downconverter
  import axis_pkg::*;
#(
  parameter int IN_WIDTH  = AXIS_IN_WIDTH,
  parameter int OUT_WIDTH = AXIS_OUT_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast
);

  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W     = $clog2(RATIO);
  localparam int KEEP_W    = IN_WIDTH / 8;
  localparam int SEG_BYTES = OUT_WIDTH / 8;

  // Valid/ready: a beat transfers on a cycle where valid && ready. The master
  // side holds tvalid/tdata/tkeep/tlast steady until that cycle; the slave side
  // only asserts tready when the buffer is empty or is being drained this cycle.

  dc_state_t            state, state_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [IDX_W-1:0]     last_seg, cap_last_seg;
  logic [IN_WIDTH-1:0]  buf_data;
  logic [KEEP_W-1:0]    buf_keep;
  logic                 buf_last;
  logic                 at_last;
  logic                 m_fire;
  logic                 s_fire;

  assign m_axis_tvalid = (state == ST_SEND);
  assign at_last       = (idx == last_seg);
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = !areset && ((state == ST_IDLE) || (m_fire && at_last));
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = buf_data[OUT_WIDTH*idx +: OUT_WIDTH];
  assign m_axis_tkeep  = buf_keep[SEG_BYTES*idx +: SEG_BYTES];
  assign m_axis_tlast  = m_axis_tvalid && buf_last && at_last;

  // Non-final beats always emit every segment, empty ones included.
  always_comb begin
    cap_last_seg = IDX_W'(RATIO - 1);
    if (s_axis_tlast)
      cap_last_seg = IDX_W'(keep_last_seg(KEEP_MAX_W'(s_axis_tkeep), RATIO, SEG_BYTES));
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      ST_IDLE: begin
        if (s_fire) begin
          state_n = ST_SEND;
          idx_n   = '0;
        end
      end
      ST_SEND: begin
        if (m_fire) begin
          if (!at_last) begin
            idx_n = idx + 1'b1;
          end else if (s_fire) begin
            idx_n = '0;
          end else begin
            state_n = ST_IDLE;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_data <= '0;
      buf_keep <= '0;
      buf_last <= 1'b0;
      last_seg <= '0;
    end else if (s_fire) begin
      buf_data <= s_axis_tdata;
      buf_keep <= s_axis_tkeep;
      buf_last <= s_axis_tlast;
      last_seg <= cap_last_seg;
    end
  end

endmodule

// File: tb/tb_axis_width_downconverter.sv
// Bench for axis_width_downconverter: directed timing cases plus random
// packets checked byte-exact against a segment-list reference model.
module tb_axis_width_downconverter;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int R     = IN_W / OUT_W;
  localparam int KW    = IN_W / 8;
  localparam int OKW   = OUT_W / 8;
  localparam int EW    = OUT_W + OKW + 1;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [IN_W-1:0]  s_axis_tdata = '0;
  logic [KW-1:0]    s_axis_tkeep = '0;
  logic             s_axis_tlast = 1'b0;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic [OUT_W-1:0] m_axis_tdata;
  logic [OKW-1:0]   m_axis_tkeep;
  logic             m_axis_tlast;

  axis_width_downconverter #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;   // 0: downstream always ready, 1: random 50%

  logic [EW-1:0] exp_q[$];
  int            fire_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Narrow beats = segments 0..n-1; n = R unless tlast, where n reaches the
  // segment holding the highest enabled byte (at least one segment).
  task automatic model_push(input logic [IN_W-1:0] d, input logic [KW-1:0] k, input logic l);
    int hb, nseg;
    hb = -1;
    for (int b = KW - 1; b >= 0; b--) begin
      if (k[b]) begin
        hb = b;
        break;
      end
    end
    if (!l)          nseg = R;
    else if (hb < 0) nseg = 1;
    else             nseg = hb / OKW + 1;
    for (int s = 0; s < nseg; s++)
      exp_q.push_back({(l && s == nseg - 1), k[s*OKW +: OKW], d[s*OUT_W +: OUT_W]});
  endtask

  // ---------------- drivers ----------------
  // Entered and left just after a rising edge; back-to-back calls leave no gap.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic [KW-1:0] k,
                           input logic l, output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        model_push(d, k, l);
        acc_cyc = cyc;
        done = 1;
      end
      @(posedge aclk);
      #1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL s_accept_timeout: got no tready expected accept within 2000 cycles");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    repeat (4) @(negedge aclk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rand_data();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic             stalled = 1'b0;
  logic [OUT_W-1:0] st_data;
  logic [OKW-1:0]   st_keep;
  logic             st_last;

  always @(negedge aclk) begin
    logic [EW-1:0] e;
    if (areset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_data", m_axis_tdata, st_data);
        chk("stall_keep", m_axis_tkeep, st_keep);
        chk("stall_last", m_axis_tlast, st_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        fire_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h last %0b expected no beat",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis_tdata, e[OUT_W-1:0]);
          chk("beat_keep", m_axis_tkeep, e[OUT_W +: OKW]);
          chk("beat_last", m_axis_tlast, e[EW-1]);
        end
        stalled = 1'b0;
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        st_data = m_axis_tdata;
        st_keep = m_axis_tkeep;
        st_last = m_axis_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [KW-1:0] ones;
    logic [KW-1:0] k;
    int a0, a1, a2, nb, nbytes;
    ones = '1;

    // reset state
    #12;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_keep_known", $isunknown(m_axis_tkeep), 0);
    @(negedge aclk); #2;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_s_tready", s_axis_tready, 1);
    chk("idle_m_tvalid", m_axis_tvalid, 0);
    @(posedge aclk); #1;

    // single full beat with tlast: 8 consecutive beats one cycle after accept
    rdy_mode = 0;
    fire_cyc_q.delete();
    send_beat(rand_data(), ones, 1'b1, a0);
    drain();
    chk("t1_beat_count", fire_cyc_q.size(), R);
    if (fire_cyc_q.size() == R)
      for (int i = 0; i < R; i++) chk("t1_beat_cycle", fire_cyc_q[i], a0 + 1 + i);

    // 10-byte last beat, next beat accepted on the cycle of its second beat
    fire_cyc_q.delete();
    k = '0;
    k[9:0] = '1;
    send_beat(rand_data(), k, 1'b1, a0);
    send_beat(rand_data(), ones, 1'b1, a1);
    drain();
    chk("t2_next_accept", a1, a0 + 2);
    chk("t2_beat_count", fire_cyc_q.size(), 2 + R);
    if (fire_cyc_q.size() >= 2) chk("t2_beat2_cycle", fire_cyc_q[1], a0 + 2);

    // three back-to-back full beats: 24 consecutive narrow beats
    fire_cyc_q.delete();
    send_beat(rand_data(), ones, 1'b0, a0);
    send_beat(rand_data(), ones, 1'b0, a1);
    send_beat(rand_data(), ones, 1'b1, a2);
    drain();
    chk("t3_accept2", a1, a0 + R);
    chk("t3_accept3", a2, a0 + 2 * R);
    chk("t3_beat_count", fire_cyc_q.size(), 3 * R);
    if (fire_cyc_q.size() == 3 * R)
      for (int i = 0; i < 3 * R; i++) chk("t3_beat_cycle", fire_cyc_q[i], a0 + 1 + i);

    // tlast with all-zero keep: exactly one empty beat carrying tlast
    fire_cyc_q.delete();
    send_beat(rand_data(), '0, 1'b1, a0);
    drain();
    chk("t5_beat_count", fire_cyc_q.size(), 1);

    // reset while the third narrow beat is presented
    send_beat(rand_data(), ones, 1'b1, a0);
    while (cyc < a0 + 3) @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    chk("rst_mid_m_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_m_tlast", m_axis_tlast, 0);
    chk("rst_mid_s_tready", s_axis_tready, 0);
    exp_q.delete();
    repeat (2) @(negedge aclk);
    #2;
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_m_tvalid", m_axis_tvalid, 0);
    @(posedge aclk); #1;
    fire_cyc_q.delete();
    send_beat(rand_data(), ones, 1'b1, a0);
    drain();
    chk("post_rst_beat_count", fire_cyc_q.size(), R);

    // random packets with 50% downstream ready
    rdy_mode = 1;
    for (int p = 0; p < 100; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1) begin
          if ($urandom_range(0, 3) == 0) begin
            k = rand_data()[KW-1:0];
            if (k == '0) k[0] = 1'b1;
          end else begin
            nbytes = $urandom_range(1, KW);
            k = '0;
            for (int i = 0; i < nbytes; i++) k[i] = 1'b1;
          end
        end else begin
          k = ($urandom_range(0, 7) == 0) ? rand_data()[KW-1:0] : ones;
        end
        send_beat(rand_data(), k, (b == nb - 1), a0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
